// File: rtl/xwalk_scheduler_pkg.sv
// xwalk_scheduler_pkg
//   Shared definitions for the crosswalk scheduler: the phase state
//   encoding, the default phase durations and a constant clog2 helper.
//   The PREEMPT state exists only when XWALK_PREEMPT_EN is defined.
package xwalk_scheduler_pkg;

  localparam int DEF_T_GREEN  = 8;
  localparam int DEF_T_YELLOW = 3;
  localparam int DEF_T_CLEAR  = 2;
  localparam int DEF_T_WALK   = 6;
  localparam int DEF_T_FLASH  = 4;

  typedef enum logic [2:0] {
    ST_CAR_GREEN  = 3'd0,
    ST_CAR_YELLOW = 3'd1,
    ST_ALL_RED1   = 3'd2,
    ST_WALK       = 3'd3,
    ST_WALK_END   = 3'd4,
    ST_ALL_RED2   = 3'd5
`ifdef XWALK_PREEMPT_EN
    , ST_PREEMPT  = 3'd6
`endif
  } state_e;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/xwalk_scheduler_sync_edge.sv
// sync_edge
//   Two-flop synchroniser for an asynchronous level input, plus a
//   one-cycle pulse on the synchronised rising edge.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (all flops to 0)
//   d     : asynchronous input level
//   level : synchronised level
//   rise  : single-cycle pulse when level goes 0 -> 1
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q;
  // A held-high input produces exactly one pulse.
  assign rise  = sync_q & ~prev_q;

endmodule

// File: rtl/xwalk_scheduler.sv
// xwalk_scheduler
//   Pedestrian-crossing scheduler driving the vehicle and walk heads of
//   one crosswalk. Latches push-button requests, enforces a minimum
//   vehicle green and sequences yellow / all-red / walk / orange-walk /
//   all-red from one saturating down-counter.
//   Optional feature macro: XWALK_PREEMPT_EN (adds preempt port and the
//   PREEMPT state).
// Ports:
//   clk                              rising-edge clock
//   reset                            asynchronous active-low reset
//   button                           async push-button level
//   preempt                          async emergency preemption (macro only)
//   car_green/car_yellow/car_red     vehicle head, one-hot
//   green_walk/orange_walk/red_hand  pedestrian head, one-hot
//   req_pending                      latched request ("wait" lamp)
module xwalk_scheduler
  import xwalk_scheduler_pkg::*;
#(
  parameter int T_GREEN  = DEF_T_GREEN,
  parameter int T_YELLOW = DEF_T_YELLOW,
  parameter int T_CLEAR  = DEF_T_CLEAR,
  parameter int T_WALK   = DEF_T_WALK,
  parameter int T_FLASH  = DEF_T_FLASH
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
`ifdef XWALK_PREEMPT_EN
  input  logic preempt,
`endif
  output logic car_green,
  output logic car_yellow,
  output logic car_red,
  output logic green_walk,
  output logic orange_walk,
  output logic red_hand,
  output logic req_pending
);

  if (T_GREEN < 1 || T_YELLOW < 1 || T_CLEAR < 1 || T_WALK < 1 || T_FLASH < 1) begin : g_bad_duration
    $error("xwalk_scheduler: every phase duration must be at least 1");
  end

  localparam int T_MAX = imax(imax(imax(T_GREEN, T_YELLOW), imax(T_CLEAR, T_WALK)), T_FLASH);
  localparam int CW    = (clog2(T_MAX) < 1) ? 1 : clog2(T_MAX);

  typedef logic [CW-1:0] cnt_t;

  // Counter load value for a freshly entered state.
  function automatic cnt_t dur_m1(input state_e s);
    case (s)
      ST_CAR_GREEN:  return cnt_t'(T_GREEN - 1);
      ST_CAR_YELLOW: return cnt_t'(T_YELLOW - 1);
      ST_ALL_RED1:   return cnt_t'(T_CLEAR - 1);
      ST_WALK:       return cnt_t'(T_WALK - 1);
      ST_WALK_END:   return cnt_t'(T_FLASH - 1);
      ST_ALL_RED2:   return cnt_t'(T_CLEAR - 1);
      default:       return '0;
    endcase
  endfunction

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   req_q, req_d;
  logic   btn_level_unused;
  logic   btn_rise;
  logic   pre_s;
  logic   expired;

  sync_edge u_btn_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (button),
    .level (btn_level_unused),
    .rise  (btn_rise)
  );

`ifdef XWALK_PREEMPT_EN
  logic pre_rise_unused;
  sync_edge u_pre_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (preempt),
    .level (pre_s),
    .rise  (pre_rise_unused)
  );
`else
  assign pre_s = 1'b0;
`endif

  assign expired = (cnt_q == '0);

  // Next state: preempt outranks counter expiry, which outranks the request.
  always_comb begin
    state_d = state_q;
    cnt_d   = expired ? '0 : cnt_q - cnt_t'(1);
    case (state_q)
      ST_CAR_GREEN: begin
        if (pre_s)                   state_d = ST_CAR_YELLOW;
        else if (expired && req_q)   state_d = ST_CAR_YELLOW;
      end
      ST_CAR_YELLOW: if (expired) state_d = ST_ALL_RED1;
      ST_ALL_RED1: begin
        if (expired) begin
          state_d = ST_WALK;
`ifdef XWALK_PREEMPT_EN
          if (pre_s) state_d = ST_PREEMPT;
`endif
        end
      end
      ST_WALK:     if (pre_s || expired) state_d = ST_WALK_END;
      ST_WALK_END: if (expired) state_d = ST_ALL_RED2;
      ST_ALL_RED2: begin
        if (expired) begin
          state_d = ST_CAR_GREEN;
`ifdef XWALK_PREEMPT_EN
          if (pre_s) state_d = ST_PREEMPT;
`endif
        end
      end
`ifdef XWALK_PREEMPT_EN
      ST_PREEMPT: if (!pre_s) state_d = ST_CAR_GREEN;
`endif
      default: state_d = ST_CAR_GREEN;
    endcase
    // Any state change reloads the counter, giving the new state its full duration.
    if (state_d != state_q) cnt_d = dur_m1(state_d);
  end

  // Request latch: presses during the walk phases are dropped; entering
  // WALK services the request, and that clear beats a same-cycle set.
  always_comb begin
    req_d = req_q;
    if (btn_rise && state_q != ST_WALK && state_q != ST_WALK_END) req_d = 1'b1;
    if (state_d == ST_WALK && state_q != ST_WALK)                 req_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CAR_GREEN;
      cnt_q   <= cnt_t'(T_GREEN - 1);
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Heads decoded from registered state only, so reset acts on them at once.
  always_comb begin
    car_green   = 1'b0;
    car_yellow  = 1'b0;
    car_red     = 1'b0;
    green_walk  = 1'b0;
    orange_walk = 1'b0;
    red_hand    = 1'b0;
    case (state_q)
      ST_CAR_GREEN:  begin car_green  = 1'b1; red_hand    = 1'b1; end
      ST_CAR_YELLOW: begin car_yellow = 1'b1; red_hand    = 1'b1; end
      ST_WALK:       begin car_red    = 1'b1; green_walk  = 1'b1; end
      ST_WALK_END:   begin car_red    = 1'b1; orange_walk = 1'b1; end
      default:       begin car_red    = 1'b1; red_hand    = 1'b1; end
    endcase
  end

  assign req_pending = req_q;

endmodule

// File: tb/tb_xwalk_scheduler.sv
// tb_xwalk_scheduler
//   Scoreboard bench: a phase/age reference model pushes the expected
//   head outputs after every clock edge (or reset); a monitor pops and
//   compares on each falling edge. Directed scenarios plus a random tail.
module tb_xwalk_scheduler;

  localparam int TG = 8, TY = 3, TC = 2, TW = 6, TF = 4;
  localparam int W_GREEN = 0, W_YELLOW = 1, W_WALK = 2, W_WEND = 3, W_REQ = 4, W_ALLRED = 5;

  logic clk = 1'b0, reset = 1'b1, button = 1'b0;
  logic car_green, car_yellow, car_red, green_walk, orange_walk, red_hand, req_pending;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {logic cg, cy, cr, gw, ow, rh, rq;} obs_t;
  obs_t exp_q[$];

  typedef enum int {P_GREEN, P_YELLOW, P_RED1, P_WALK, P_WEND, P_RED2} phase_e;
  phase_e m_ph  = P_GREEN;
  int     m_age = 1;      // cycles spent in the current phase, including this one
  bit     m_req = 1'b0;
  bit     hist [4];       // button at the last 4 edges, hist[3] newest

  xwalk_scheduler #(.T_GREEN(TG), .T_YELLOW(TY), .T_CLEAR(TC), .T_WALK(TW), .T_FLASH(TF)) dut (
    .clk         (clk),
    .reset       (reset),
    .button      (button),
`ifdef XWALK_PREEMPT_EN
    .preempt     (1'b0),
`endif
    .car_green   (car_green),
    .car_yellow  (car_yellow),
    .car_red     (car_red),
    .green_walk  (green_walk),
    .orange_walk (orange_walk),
    .red_hand    (red_hand),
    .req_pending (req_pending)
  );

  always #5 clk = ~clk;

  function automatic int dur(input phase_e p);
    case (p)
      P_GREEN:  return TG;
      P_YELLOW: return TY;
      P_WALK:   return TW;
      P_WEND:   return TF;
      default:  return TC;
    endcase
  endfunction

  function automatic phase_e succ(input phase_e p);
    case (p)
      P_GREEN:  return P_YELLOW;
      P_YELLOW: return P_RED1;
      P_RED1:   return P_WALK;
      P_WALK:   return P_WEND;
      P_WEND:   return P_RED2;
      default:  return P_GREEN;
    endcase
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o.cg = (m_ph == P_GREEN);
    o.cy = (m_ph == P_YELLOW);
    o.cr = !(m_ph == P_GREEN || m_ph == P_YELLOW);
    o.gw = (m_ph == P_WALK);
    o.ow = (m_ph == P_WEND);
    o.rh = !(m_ph == P_WALK || m_ph == P_WEND);
    o.rq = m_req;
    return o;
  endfunction

  function automatic obs_t dut_out();
    return {car_green, car_yellow, car_red, green_walk, orange_walk, red_hand, req_pending};
  endfunction

  // Reference model
  initial begin : model
    bit rise, done;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_ph = P_GREEN; m_age = 1; m_req = 1'b0;
        for (int i = 0; i < 4; i++) hist[i] = 1'b0;
        exp_q.delete();
        exp_q.push_back(model_out());
      end else begin
        hist[0] = hist[1]; hist[1] = hist[2]; hist[2] = hist[3]; hist[3] = button;
        // A press is seen two edges after it is first sampled (synchroniser).
        rise = hist[1] && !hist[0];
        done = (m_age >= dur(m_ph)) && (m_ph != P_GREEN || m_req);
        if (rise && m_ph != P_WALK && m_ph != P_WEND) m_req = 1'b1;
        if (done) begin
          m_ph  = succ(m_ph);
          m_age = 1;
          if (m_ph == P_WALK) m_req = 1'b0;
        end else begin
          m_age++;
        end
        exp_q.push_back(model_out());
      end
    end
  end

  // Monitor
  initial begin : monitor
    obs_t a, e;
    forever begin
      @(negedge clk);
      a = dut_out();
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got %b, no expected entry", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL heads @%0t: got %b required %b (cg cy cr gw ow rh rq)", $time, a, e);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic bit sig_val(input int w);
    case (w)
      W_GREEN:  return car_green;
      W_YELLOW: return car_yellow;
      W_WALK:   return green_walk;
      W_WEND:   return orange_walk;
      W_REQ:    return req_pending;
      default:  return car_red && red_hand;
    endcase
  endfunction

  task automatic wait_sig(input int w, input int bound, output int n);
    n = 0;
    while (!sig_val(w) && n < bound) begin
      step();
      n++;
    end
    if (!sig_val(w)) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_sig%0d: not seen within %0d cycles", w, bound);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic press();
    button = 1'b1;
    step();
    step();
    button = 1'b0;
  endtask

  initial begin : stim
    int n, n2;
    #1;
    // Idle: green holds with no request.
    do_reset();
    repeat (50) step();
    chk("idle_green", car_green, 1);
    chk("idle_red_hand", red_hand, 1);
    chk("idle_req", req_pending, 0);

    // Early request: latched 3 edges after press, yellow at edge T_GREEN.
    do_reset();
    step();
    button = 1'b1;
    wait_sig(W_REQ, 20, n);
    chk("req_edge", n + 1, 4);
    wait_sig(W_YELLOW, 20, n2);
    chk("yellow_edge", n + n2 + 1, TG);
    button = 1'b0;
    wait_sig(W_WALK, 20, n);
    chk("req_clear_at_walk", req_pending, 0);
    n = 0;
    while (green_walk && n < 20) begin step(); n++; end
    chk("walk_len", n, TW);
    n = 0;
    while (orange_walk && n < 20) begin step(); n++; end
    chk("flash_len", n, TF);
    wait_sig(W_GREEN, 20, n);
    chk("clear2_len", n, TC);

    // Late request: yellow one cycle after req_pending rises.
    do_reset();
    repeat (30) step();
    press();
    wait_sig(W_REQ, 10, n);
    step();
    chk("late_yellow", car_yellow, 1);
    wait_sig(W_GREEN, 40, n);

    // Press during WALK is ignored; green then holds.
    press();
    wait_sig(W_WALK, 40, n);
    press();
    wait_sig(W_GREEN, 40, n);
    repeat (40) step();
    chk("walk_press_req", req_pending, 0);
    chk("walk_press_hold", car_green, 1);

    // Press during ALL_RED2: next yellow exactly T_GREEN after green entry.
    press();
    wait_sig(W_WEND, 40, n);
    wait_sig(W_ALLRED, 10, n);
    button = 1'b1;
    step();
    step();
    button = 1'b0;
    chk("ar2_green_entry", car_green, 1);
    wait_sig(W_YELLOW, 20, n);
    chk("ar2_min_green", n, TG);

    // Asynchronous reset in the 3rd WALK cycle.
    wait_sig(W_WALK, 20, n);
    step();
    step();
    #1 reset = 1'b0;
    #1;
    chk("async_car_green", car_green, 1);
    chk("async_car_yellow", car_yellow, 0);
    chk("async_car_red", car_red, 0);
    chk("async_green_walk", green_walk, 0);
    chk("async_orange_walk", orange_walk, 0);
    chk("async_red_hand", red_hand, 1);
    chk("async_req", req_pending, 0);
    step();
    reset = 1'b1;

    // Random tail with occasional mid-cycle reset pulses.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) button = ~button;
      if ($urandom_range(0, 399) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
      step();
    end
    button = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
